// File: rtl/cpu_supervisor_pkg.sv
// cpu_supervisor_pkg
// Shared types and default constants for the CPU supervisor.
//   state_e                 : supervisor FSM state (S_HOLD holds RESETn low, S_RUN releases it)
//   DEFAULT_RESET_HOLD      : cycles RESETn is held low after any reset cause
//   DEFAULT_WDOG_LIMIT      : vblank rises without a clear that fire the watchdog
//   DEFAULT_IRQ_PERIOD_LOG2 : IRQ tick every 2^n scanlines
package cpu_supervisor_pkg;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_RESET_HOLD      = 32;
    localparam int unsigned DEFAULT_WDOG_LIMIT      = 8;
    localparam int unsigned DEFAULT_IRQ_PERIOD_LOG2 = 6;

endpackage

// File: rtl/cpu_supervisor_if.sv
// cpu_supervisor_if
// Bundles the video-timing / decoder inputs and the CPU control outputs of the supervisor.
//   line_strobe : one-cycle pulse per scanline, vcount valid with it
//   vcount      : current scanline number
//   vblank      : vertical blank level
//   wdog_clr    : one-cycle watchdog clear strobe
//   RESETn      : active-low CPU/system reset
//   IRQCK       : one-cycle IRQ clock pulse
//   wdog_fired  : sticky watchdog-expiry flag
// master drives the inputs (system side), slave is the supervisor.
interface cpu_supervisor_if;

    logic       line_strobe;
    logic [7:0] vcount;
    logic       vblank;
    logic       wdog_clr;
    logic       RESETn;
    logic       IRQCK;
    logic       wdog_fired;

    modport master (
        output line_strobe, vcount, vblank, wdog_clr,
        input  RESETn, IRQCK, wdog_fired
    );

    modport slave (
        input  line_strobe, vcount, vblank, wdog_clr,
        output RESETn, IRQCK, wdog_fired
    );

endinterface

// File: rtl/rise_detect.sv
// rise_detect
// Registered rising-edge detector: rise is high for one cycle, one clock after din goes 0->1.
//   clk   : system clock
//   reset : synchronous active-high reset (clears the edge history)
//   din   : level input
//   rise  : registered rising-edge pulse
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= din;
            rise_q <= din & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/cpu_supervisor.sv
// cpu_supervisor
// Generates the CPU reset and the periodic IRQ clock, with an optional vblank watchdog.
// After any reset cause RESETn is held low for RESET_HOLD cycles. IRQCK pulses one clock after
// a scanline strobe whose vcount is a multiple of 2^IRQ_PERIOD_LOG2, only while running.
// Optional feature macro: CPU_SUPERVISOR_WATCHDOG_EN. When defined, WDOG_LIMIT vblank rises
// without a wdog_clr restart the hold and set the sticky wdog_fired flag; otherwise vblank and
// wdog_clr are ignored and wdog_fired is tied low.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : cpu_supervisor_if.slave (line_strobe, vcount, vblank, wdog_clr -> RESETn, IRQCK,
//           wdog_fired)
module cpu_supervisor
    import cpu_supervisor_pkg::*;
#(
    parameter int unsigned RESET_HOLD      = DEFAULT_RESET_HOLD,
    parameter int unsigned WDOG_LIMIT      = DEFAULT_WDOG_LIMIT,
    parameter int unsigned IRQ_PERIOD_LOG2 = DEFAULT_IRQ_PERIOD_LOG2
) (
    input logic             clk,
    input logic             reset,
    cpu_supervisor_if.slave bus
);

    localparam int unsigned HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    state_e        state_q;
    logic [HW-1:0] hold_cnt_q;
    logic          resetn_q;
    logic          irqck_q;
    logic          expire;
    logic          irq_hit;
    logic          unused_vcount;

    assign irq_hit       = bus.line_strobe && (bus.vcount[IRQ_PERIOD_LOG2-1:0] == '0);
    assign unused_vcount = ^bus.vcount;

`ifdef CPU_SUPERVISOR_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_LIMIT - 1);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_LIMIT);

    logic          vblank_rise;
    logic [WW-1:0] wdog_cnt_q;
    logic          fired_q;

    rise_detect u_vblank_rise (
        .clk   (clk),
        .reset (reset),
        .din   (bus.vblank),
        .rise  (vblank_rise)
    );

    // A coincident clear wins over the expiring rise.
    assign expire = (state_q == S_RUN) && vblank_rise && !bus.wdog_clr &&
                    (wdog_cnt_q == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt_q <= '0;
            fired_q    <= 1'b0;
        end else begin
            if (state_q == S_HOLD || bus.wdog_clr) begin
                wdog_cnt_q <= '0;
            end else if (vblank_rise && wdog_cnt_q != WDOG_MAX) begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end
            if (expire) begin
                fired_q <= 1'b1;
            end
        end
    end

    assign bus.wdog_fired = fired_q;
`else
    logic unused_wdog;

    assign unused_wdog    = bus.vblank ^ bus.wdog_clr;
    assign expire         = 1'b0;
    assign bus.wdog_fired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            resetn_q   <= 1'b0;
            irqck_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    // Strobes during hold, including the exit cycle, never reach IRQCK.
                    irqck_q <= 1'b0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q  <= S_RUN;
                        resetn_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    irqck_q <= irq_hit;
                    if (expire) begin
                        state_q    <= S_HOLD;
                        hold_cnt_q <= '0;
                        resetn_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_HOLD;
                    hold_cnt_q <= '0;
                    resetn_q   <= 1'b0;
                    irqck_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RESETn = resetn_q;
    assign bus.IRQCK  = irqck_q;

endmodule
